// File: rtl/dm_sba_controller.sv
// dm_sba_controller: System Bus Access sequencer for the RISC-V debug module.
// Holds sbaddress0, sbdata0 and the sbcs error flags. Turns DMI-side triggers into
// single transactions on a req/gnt/rvalid bus with byte lanes and auto-increment.
// Optional feature: define SBA_TIMEOUT_EN to abort a bus phase after TIMEOUT_CYCLES.
module dm_sba_controller #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cfg_sbaccess,
   input  logic        cfg_autoinc,
   input  logic        cfg_readonaddr,
   input  logic        cfg_readondata,
   input  logic        addr_wr_valid,
   input  logic [31:0] addr_wr_data,
   input  logic        data_wr_valid,
   input  logic [31:0] data_wr_data,
   input  logic        data_rd_valid,
   input  logic [2:0]  err_clr,
   input  logic        busyerr_clr,
   output logic [31:0] sbaddress,
   output logic [31:0] sbdata,
   output logic        sbbusy,
   output logic        sbbusyerror,
   output logic [2:0]  sberror,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   localparam logic [2:0] ERR_TIMEOUT    = 3'd1;
   localparam logic [2:0] ERR_BUS        = 3'd2;
   localparam logic [2:0] ERR_MISALIGNED = 3'd3;
   localparam logic [2:0] ERR_SIZE       = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   // Size and direction of the access in flight, frozen when it starts so that
   // cfg_sbaccess changes mid-transaction cannot disturb the bus lanes.
   logic [1:0]  acc_size;
   logic        acc_we;

   logic        trig_any;
   logic        trig_multi;
   logic        blocked;
   logic        want_access;
   logic        want_we;
   logic [31:0] cand_addr;
   logic        size_bad;
   logic        misaligned;
   logic        check_on;
   logic        start;
   logic        precheck_fail;
   logic [2:0]  precheck_err;

   logic        complete;
   logic        timeout;
   logic        tmo_hit;

   logic [31:0] rd_shifted;
   logic [31:0] rd_lane;
   logic [31:0] addr_inc;

   logic [31:0] addr_next;
   logic [31:0] data_next;
   logic [2:0]  err_next;
   logic        busyerr_next;

   logic [3:0]  be_raw;
   logic [31:0] wdata_raw;

`ifdef SBA_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;

   // Per-phase cycle counter; restarts whenever REQ or RESP is (re)entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == IDLE || state_next != state) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign tmo_hit = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign tmo_hit            = 1'b0;
`endif

   // Trigger arbitration and pre-checks: decide whether an access may start this cycle.
   always_comb begin
      trig_any    = addr_wr_valid | data_wr_valid | data_rd_valid;
      trig_multi  = (addr_wr_valid & data_wr_valid) | (addr_wr_valid & data_rd_valid) |
                    (data_wr_valid & data_rd_valid);
      blocked     = (sberror != 3'd0) | sbbusyerror;
      want_access = 1'b0;
      want_we     = 1'b0;
      cand_addr   = sbaddress;
      if (addr_wr_valid) begin
         want_access = cfg_readonaddr;
         cand_addr   = addr_wr_data;
      end else if (data_wr_valid) begin
         want_access = 1'b1;
         want_we     = 1'b1;
      end else if (data_rd_valid) begin
         want_access = cfg_readondata;
      end
      size_bad = (cfg_sbaccess > 3'd2);
      case (cfg_sbaccess[1:0])
         2'd1:    misaligned = cand_addr[0];
         2'd2:    misaligned = |cand_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      check_on      = (state == IDLE) & want_access & ~blocked;
      start         = check_on & ~size_bad & ~misaligned;
      precheck_fail = check_on & ~start;
      precheck_err  = 3'd0;
      if (precheck_fail) begin
         precheck_err = size_bad ? ERR_SIZE : ERR_MISALIGNED;
      end
   end

   // Next-state logic for the IDLE -> REQ -> RESP -> IDLE bus sequencer.
   always_comb begin
      state_next = state;
      complete   = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus_gnt && bus_rvalid) begin
               state_next = IDLE;
               complete   = 1'b1;
            end else if (bus_gnt) begin
               state_next = RESP;
            end else if (tmo_hit) begin
               state_next = IDLE;
               timeout    = 1'b1;
            end
         end
         RESP: begin
            if (bus_rvalid) begin
               state_next = IDLE;
               complete   = 1'b1;
            end else if (tmo_hit) begin
               state_next = IDLE;
               timeout    = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Read-lane extraction and auto-increment step for the access in flight.
   always_comb begin
      rd_shifted = bus_rdata >> {sbaddress[1:0], 3'b000};
      case (acc_size)
         2'd0:    rd_lane = {24'd0, rd_shifted[7:0]};
         2'd1:    rd_lane = {16'd0, rd_shifted[15:0]};
         default: rd_lane = rd_shifted;
      endcase
      addr_inc = 32'd1 << acc_size;
   end

   // Register updates: trigger loads, busy/precheck errors, completion and timeout effects.
   always_comb begin
      addr_next    = sbaddress;
      data_next    = sbdata;
      err_next     = sberror & ~err_clr;
      busyerr_next = sbbusyerror & ~busyerr_clr;
      if (state == IDLE) begin
         if (addr_wr_valid) begin
            if (!precheck_fail) begin
               addr_next = addr_wr_data;
            end
         end else if (data_wr_valid) begin
            data_next = data_wr_data;
         end
         if (trig_multi) begin
            busyerr_next = 1'b1;
         end
         if (precheck_fail) begin
            err_next = precheck_err;
         end
      end else if (trig_any) begin
         busyerr_next = 1'b1;
      end
      if (complete) begin
         if (bus_err) begin
            err_next = ERR_BUS;
         end else begin
            if (!acc_we) begin
               data_next = rd_lane;
            end
            if (cfg_autoinc) begin
               addr_next = sbaddress + addr_inc;
            end
         end
      end
      if (timeout) begin
         err_next = ERR_TIMEOUT;
      end
   end

   // State register; async reset drops bus_req immediately and abandons any response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Architectural registers and the frozen access attributes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbaddress   <= 32'd0;
         sbdata      <= 32'd0;
         sberror     <= 3'd0;
         sbbusyerror <= 1'b0;
         acc_size    <= 2'd0;
         acc_we      <= 1'b0;
      end else begin
         sbaddress   <= addr_next;
         sbdata      <= data_next;
         sberror     <= err_next;
         sbbusyerror <= busyerr_next;
         if (start) begin
            acc_size <= cfg_sbaccess[1:0];
            acc_we   <= want_we;
         end
      end
   end

   // Byte enables and lane-replicated write data for the frozen access size.
   always_comb begin
      case (acc_size)
         2'd0: begin
            be_raw    = 4'b0001 << sbaddress[1:0];
            wdata_raw = {4{sbdata[7:0]}};
         end
         2'd1: begin
            be_raw    = 4'b0011 << sbaddress[1:0];
            wdata_raw = {2{sbdata[15:0]}};
         end
         default: begin
            be_raw    = 4'b1111;
            wdata_raw = sbdata;
         end
      endcase
   end

   assign sbbusy    = (state != IDLE);
   assign bus_req   = (state == REQ);
   assign bus_we    = bus_req & acc_we;
   assign bus_addr  = bus_req ? {sbaddress[31:2], 2'b00} : 32'd0;
   assign bus_be    = bus_req ? be_raw : 4'd0;
   assign bus_wdata = bus_req ? wdata_raw : 32'd0;

endmodule
